// File: rtl/demux_1by8_pkg.sv
// Shared constants and the select-to-one-hot helper for the 1-to-8 demux.
package demux_1by8_pkg;

    localparam int NUM_OUT = 8;
    localparam int SEL_W   = 3;

    // Bit K-1 of the result corresponds to output yK.
    function automatic logic [NUM_OUT-1:0] onehot_decode(
        input logic [SEL_W-1:0] sel
    );
        logic [NUM_OUT-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux_1by8_decoder.sv
// Combinational 3-to-8 one-hot select decoder.
module demux_1by8_decoder
    import demux_1by8_pkg::*;
(
    input  logic [SEL_W-1:0]   i_sel,
    output logic [NUM_OUT-1:0] o_onehot
);

    assign o_onehot = onehot_decode(i_sel);

endmodule

// File: rtl/demux_1by8.sv
// Registered 1-to-8 demux; define DEMUX_1BY8_SEL_OUT_EN to add the
// registered select (sel_q) and activity (act_q) outputs.
module demux_1by8
    import demux_1by8_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] m,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y4,
    output logic [WIDTH-1:0] y5,
    output logic [WIDTH-1:0] y6,
    output logic [WIDTH-1:0] y7,
    output logic [WIDTH-1:0] y8
`ifdef DEMUX_1BY8_SEL_OUT_EN
    ,
    output logic [SEL_W-1:0] sel_q,
    output logic             act_q
`endif
);

    logic [SEL_W-1:0]   w_sel;
    logic [NUM_OUT-1:0] w_onehot;
    logic [WIDTH-1:0]   w_lane [NUM_OUT];
    logic [WIDTH-1:0]   r_y    [NUM_OUT];

    assign w_sel = {s0, s1, s2};

    demux_1by8_decoder u_dec (
        .i_sel    (w_sel),
        .o_onehot (w_onehot)
    );

    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            w_lane[k] = m & {WIDTH{w_onehot[k]}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                r_y[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                r_y[k] <= w_lane[k];
            end
        end
    end

    assign y1 = r_y[0];
    assign y2 = r_y[1];
    assign y3 = r_y[2];
    assign y4 = r_y[3];
    assign y5 = r_y[4];
    assign y6 = r_y[5];
    assign y7 = r_y[6];
    assign y8 = r_y[7];

`ifdef DEMUX_1BY8_SEL_OUT_EN
    logic [SEL_W-1:0] r_sel;
    logic             r_act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel <= '0;
            r_act <= 1'b0;
        end else begin
            r_sel <= w_sel;
            r_act <= |m;
        end
    end

    assign sel_q = r_sel;
    assign act_q = r_act;
`endif

endmodule

// File: tb/tb_demux_1by8.sv
// Randomized and directed checks of demux_1by8 against a sample-and-shift model.
module tb_demux_1by8;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] m;
    logic [2:0]   sel;
    logic [W-1:0] y1, y2, y3, y4, y5, y6, y7, y8;
`ifdef DEMUX_1BY8_SEL_OUT_EN
    logic [2:0]   sel_q;
    logic         act_q;
`endif

    int tests = 0;
    int fails = 0;

    demux_1by8 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .m   (m),
        .s0  (sel[2]),
        .s1  (sel[1]),
        .s2  (sel[0]),
        .y1  (y1),
        .y2  (y2),
        .y3  (y3),
        .y4  (y4),
        .y5  (y5),
        .y6  (y6),
        .y7  (y7),
        .y8  (y8)
`ifdef DEMUX_1BY8_SEL_OUT_EN
        ,
        .sel_q (sel_q),
        .act_q (act_q)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [63:0] act_vec;
    assign act_vec = {y8, y7, y6, y5, y4, y3, y2, y1};

    // Model: outputs show the last (m, sel) sampled, or nothing since reset.
    logic [W-1:0] mdl_m;
    logic [2:0]   mdl_sel;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_m   = '0;
            mdl_sel = '0;
        end else begin
            mdl_m   = m;
            mdl_sel = sel;
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %016h expected %016h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Literal expectation: lane (0..7) carries val, every other lane zero.
    task automatic check_lane(input string name, input int lane,
                              input logic [W-1:0] val);
        logic [63:0] exp;
        exp = '0;
        if (lane >= 0) exp[lane*8 +: 8] = val;
        check(name, act_vec, exp);
    endtask

    always @(negedge clk) begin
        check("model", act_vec, 64'(mdl_m) << (8 * mdl_sel));
`ifdef DEMUX_1BY8_SEL_OUT_EN
        check("model_sel_q", 64'(sel_q), 64'(mdl_sel));
        check("model_act_q", 64'(act_q), 64'(mdl_m != 0));
`endif
    end

    task automatic drive(input logic [W-1:0] mv, input int s);
        @(negedge clk);
        m   = mv;
        sel = 3'(s);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        m   = 8'h01;
        sel = 3'd5;
        #1 rst = 1'b1;
        #1 check_lane("reset_async", -1, 8'h00);
        @(posedge clk); #1;
        check_lane("reset_hold1", -1, 8'h00);
        @(posedge clk); #1;
        check_lane("reset_hold2", -1, 8'h00);
        @(negedge clk) rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            drive(8'h01, k);
            check_lane($sformatf("sweep1_sel%0d", k), k, 8'h01);
        end

        for (int k = 0; k < 8; k++) begin
            drive(8'h00, k);
            check_lane($sformatf("sweep0_sel%0d", k), -1, 8'h00);
        end

        drive(8'h01, 0);
        @(negedge clk);
        sel = 3'd7;
        #1 check_lane("latency_hold_y1", 0, 8'h01);
        @(posedge clk); #1;
        check_lane("latency_y8", 7, 8'h01);

        drive(8'h01, 3);
        check_lane("midrst_pre", 3, 8'h01);
        #2 rst = 1'b1;
        #1 check_lane("midrst_async", -1, 8'h00);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check_lane("midrst_post", 3, 8'h01);

        drive(8'hA5, 6);
        check_lane("wide_a5_y7", 6, 8'hA5);
`ifdef DEMUX_1BY8_SEL_OUT_EN
        check("wide_sel_q", 64'(sel_q), 64'd6);
        check("wide_act_q", 64'(act_q), 64'd1);
`endif

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            m   = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            sel = 3'($urandom);
            if ($urandom_range(0, 40) == 0) begin
                #2 rst = 1'b1;
                #1 check_lane("rand_async_rst", -1, 8'h00);
                @(negedge clk) rst = 1'b0;
            end
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
